// File: rtl/apb_timer.sv
// apb_timer: APB slave exposing a prescaled 32-bit down-counter with
// auto-reload, a sticky TIMEOUT flag and a level interrupt.
// Optional build macro APB_TIMER_PSTRB_EN: writes honour PSTRB byte lanes.
// Without it, PSTRB is ignored and every write updates the full word.
//
// Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0). The
// access phase (PSEL=1, PENABLE=1) lasts WAIT_CYCLES+1 cycles. PREADY,
// PRDATA and PSLVERR are registers, and all three are valid together in
// the final access cycle. The write commits on the clock edge that ends
// that cycle. Dropping PSEL before that edge aborts the transfer without
// a commit.
module apb_timer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            PSTRB,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  irq,
    output logic                  apb_state
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_t  state, state_d;
    logic [3:0]  wait_cnt, wait_d;
    logic        ready_d, commit;

    logic [2:0]  ctrl;
    logic [31:0] load;
    logic [31:0] value;
    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic        timeout;

    logic [2:0]  idx;
    logic        err, wr;
    logic [31:0] wmask, rd_data, load_new;
    logic [2:0]  ctrl_new;
    logic [15:0] presc_new;
    logic        wr_any, w1c;
    logic        wr_ctrl, wr_load, wr_presc, wr_status;
    logic        tick, ctrl_stop, tick_eff, advance;
    logic        unused;

`ifdef APB_TIMER_PSTRB_EN
    assign wmask  = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
    assign wr_any = |PSTRB;
    assign w1c    = PSTRB[0] & PWDATA[0];
    assign unused = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
`else
    assign wmask  = '1;
    assign wr_any = 1'b1;
    assign w1c    = PWDATA[0];
    assign unused = ^{PSTRB, PADDR[ADDR_WIDTH-1:5], PADDR[1:0]};
`endif

    assign idx       = PADDR[4:2];
    assign err       = (idx > 3'd4) || (PWRITE && (idx == 3'd2));
    assign wr        = commit && PWRITE && !err && wr_any;
    assign wr_ctrl   = wr && (idx == 3'd0);
    assign wr_load   = wr && (idx == 3'd1);
    assign wr_presc  = wr && (idx == 3'd3);
    assign wr_status = wr && (idx == 3'd4);

    assign load_new  = (load & ~wmask) | (PWDATA & wmask);
    assign ctrl_new  = (ctrl & ~wmask[2:0]) | (PWDATA[2:0] & wmask[2:0]);
    assign presc_new = (prescale & ~wmask[15:0]) | (PWDATA[15:0] & wmask[15:0]);

    // A CTRL write that clears EN freezes the counter in that very cycle,
    // and a LOAD write overrides any tick that lands on the same edge.
    assign tick      = ctrl[0] && (pre_cnt >= prescale);
    assign ctrl_stop = wr_ctrl && !ctrl_new[0];
    assign tick_eff  = tick && !ctrl_stop && !wr_load;
    assign advance   = ctrl[0] && !ctrl_stop;

    assign irq       = timeout & ctrl[2];
    assign apb_state = state;

    // Read mux; reserved offsets and unused bits read as zero.
    always_comb begin
        rd_data = '0;
        case (idx)
            3'd0:    rd_data = {29'b0, ctrl};
            3'd1:    rd_data = load;
            3'd2:    rd_data = value;
            3'd3:    rd_data = {16'b0, prescale};
            3'd4:    rd_data = {31'b0, timeout};
            default: rd_data = '0;
        endcase
    end

    // APB next-state: setup, counted wait states, one ready cycle, commit.
    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        ready_d = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    wait_d  = WAIT_INIT;
                    ready_d = (WAIT_INIT == 4'd0);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PREADY) begin
                    state_d = IDLE;
                    commit  = PENABLE;
                end else if (PENABLE) begin
                    wait_d  = wait_cnt - 4'd1;
                    ready_d = (wait_cnt == 4'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // APB state and registered response outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            PREADY   <= 1'b0;
            PSLVERR  <= 1'b0;
            PRDATA   <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            PREADY   <= ready_d;
            PSLVERR  <= ready_d && err;
            if (ready_d) begin
                PRDATA <= PWRITE ? '0 : rd_data;
            end
        end
    end

    // Register file, prescaler, down-counter and sticky TIMEOUT flag.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl     <= 3'b0;
            load     <= 32'b0;
            value    <= 32'b0;
            prescale <= 16'b0;
            pre_cnt  <= 16'b0;
            timeout  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= ctrl_new;
            end else if (tick_eff && (value == 32'd0) && !ctrl[1]) begin
                ctrl[0] <= 1'b0;
            end

            if (wr_presc) begin
                prescale <= presc_new;
            end

            if (wr_load) begin
                load    <= load_new;
                value   <= load_new;
                pre_cnt <= 16'b0;
            end else begin
                if (advance) begin
                    pre_cnt <= tick ? 16'b0 : pre_cnt + 16'd1;
                end
                if (tick_eff) begin
                    if (value != 32'd0) begin
                        value <= value - 32'd1;
                    end else if (ctrl[1]) begin
                        value <= load;
                    end
                end
            end

            if (tick_eff && (value == 32'd0)) begin
                timeout <= 1'b1;
            end else if (wr_status && w1c) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule
